sum_stream_display: RTL and testbench

SUM_STREAM_DISPLAY -- requirements
Module: sum_stream_display

---
 rtl/sum_stream_display.sv | 127 ++++++++++++
 tb/tb_sum_stream_display.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_stream_display.sv
// Burst accumulator: sums a valid/ready stream per start..last burst and holds
// the result, beat count, overflow and match flags, shown on seven-segment digits.
module sum_stream_display #(
  parameter  int WIDTH  = 8,
  parameter  int MAXCNT = 16,
  parameter  int SAT    = 0,
  localparam int NDIG   = WIDTH / 4,
  localparam int CW     = $clog2(MAXCNT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_last,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    exp_sum,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    sum,
  output logic [CW-1:0]       count,
  output logic                overflow,
  output logic                match,
  output logic [7*NDIG-1:0]   hex
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] post_acc;
  logic [CW-1:0]    post_cnt;
  logic             post_ovf;
  logic             beat;
  logic             final_beat;

  // Post-beat values feed both the running registers and the held results.
  always_comb begin
    sum_ext    = {1'b0, acc} + {1'b0, in_data};
    post_acc   = sum_ext[WIDTH-1:0];
    if (sum_ext[WIDTH] && (SAT != 0)) post_acc = '1;
    post_ovf   = ovf | sum_ext[WIDTH];
    post_cnt   = cnt + 1'b1;
    beat       = (state == ACCUM) && in_valid;
    final_beat = in_last || (post_cnt == CW'(MAXCNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (beat && final_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      match    <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      acc <= post_acc;
      cnt <= post_cnt;
      ovf <= post_ovf;
      if (final_beat) begin
        sum      <= post_acc;
        count    <= post_cnt;
        overflow <= post_ovf;
        match    <= (post_acc == exp_sum);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    hex = '1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      hex[7*k +: 7] = seg7(sum[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_sum_stream_display.sv
// Directed bench for sum_stream_display: wrap and saturating instances share
// stimulus; expected burst results are queued at the final beat and popped on done.
module tb_sum_stream_display;
  localparam int WIDTH  = 8;
  localparam int MAXCNT = 16;
  localparam int NDIG   = WIDTH / 4;
  localparam int CW     = $clog2(MAXCNT + 1);

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic [WIDTH-1:0] in_data, exp_sum;

  logic in_ready, busy, done, overflow, match;
  logic [WIDTH-1:0] sum;
  logic [CW-1:0] count;
  logic [7*NDIG-1:0] hex;

  logic in_ready_s, busy_s, done_s, overflow_s, match_s;
  logic [WIDTH-1:0] sum_s;
  logic [CW-1:0] count_s;
  logic [7*NDIG-1:0] hex_s;

  sum_stream_display #(.WIDTH(WIDTH), .MAXCNT(MAXCNT), .SAT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .exp_sum(exp_sum), .busy(busy),
    .done(done), .sum(sum), .count(count), .overflow(overflow), .match(match),
    .hex(hex));

  sum_stream_display #(.WIDTH(WIDTH), .MAXCNT(MAXCNT), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_s), .exp_sum(exp_sum), .busy(busy_s),
    .done(done_s), .sum(sum_s), .count(count_s), .overflow(overflow_s),
    .match(match_s), .hex(hex_s));

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             match;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic             match_s;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  int dones  = 0;

  logic [WIDTH-1:0] m_acc, m_acc_s;
  logic m_ovf, m_ovf_s;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_acc = '0; m_acc_s = '0; m_ovf = 1'b0; m_ovf_s = 1'b0; m_cnt = 0;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (done === 1'b1) begin
      dones++;
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_sat",  done_s,     1);
        check("sum",       sum,        e.sum);
        check("count",     count,      e.count);
        check("overflow",  overflow,   e.ovf);
        check("match",     match,      e.match);
        check("hex",       hex,        {SEG[e.sum[7:4]], SEG[e.sum[3:0]]});
        check("sum_sat",   sum_s,      e.sum_s);
        check("count_sat", count_s,    e.count);
        check("ovf_sat",   overflow_s, e.ovf_s);
        check("match_sat", match_s,    e.match_s);
      end
    end else if (done_s === 1'b1) begin
      check("done_wrap", done, 1);
    end
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic last);
    logic [WIDTH:0] t, ts;
    check("in_ready_beat", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_last = last;
    t  = {1'b0, m_acc} + {1'b0, d};
    ts = {1'b0, m_acc_s} + {1'b0, d};
    m_acc   = t[WIDTH-1:0];
    m_ovf   = m_ovf | t[WIDTH];
    m_acc_s = ts[WIDTH] ? '1 : ts[WIDTH-1:0];
    m_ovf_s = m_ovf_s | ts[WIDTH];
    m_cnt++;
    if (last || m_cnt == MAXCNT)
      sb.push_back('{m_acc, CW'(m_cnt), m_ovf, (m_acc == exp_sum),
                     m_acc_s, m_ovf_s, (m_acc_s == exp_sum)});
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic begin_burst();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check("busy_start", busy, 1);
  endtask

  task automatic end_burst(input string tag, input int prev_dones);
    check({tag, "_done_once"}, dones, prev_dones + 1);
    check({tag, "_ready_done"}, in_ready, 0);
    tick();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; exp_sum = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum",   sum,    0);
    check("rst_count", count,  0);
    check("rst_match", match,  0);
    check("rst_busy",  busy,   0);
    check("rst_ready", in_ready, 0);
    check("rst_hex",   hex,    14'b1000000_1000000);
    rst = 1'b0;
    tick();

    // Normal burst with an in_valid gap.
    exp_sum = 8'h0A; d0 = dones;
    begin_burst();
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    tick();
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b1);
    check("norm_done", done, 1);
    check("norm_hex_const", hex, 14'b1000000_0001000);
    end_burst("norm", d0);

    // Wrap versus saturate on carry out.
    exp_sum = 8'h00; d0 = dones;
    begin_burst();
    beat(8'hF0, 1'b0);
    beat(8'h20, 1'b1);
    check("wrap_sum_const", sum, 8'h10);
    check("wrap_ovf_const", overflow, 1);
    end_burst("wrap", d0);

    exp_sum = 8'hFF; d0 = dones;
    begin_burst();
    beat(8'hF0, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'h05, 1'b1);
    check("sat_sum_const", sum_s, 8'hFF);
    check("sat_count_const", count_s, 3);
    end_burst("sat", d0);

    // Beat limit without in_last.
    exp_sum = 8'h10; d0 = dones;
    begin_burst();
    for (int i = 0; i < MAXCNT; i++) beat(8'h01, 1'b0);
    check("max_count_const", count, 16);
    end_burst("max", d0);

    // Reset mid-burst discards the partial burst.
    d0 = dones;
    begin_burst();
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",  busy,     0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_done",  done,     0);
    check("mid_rst_sum",   sum,      0);
    check("mid_rst_count", count,    0);
    check("mid_rst_ovf",   overflow, 0);
    check("mid_rst_match", match,    0);
    check("mid_rst_hex",   hex,      14'b1000000_1000000);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick();
    check("mid_rst_no_done", dones, d0);
    check("mid_rst_idle", busy, 0);

    // Start held high through ACCUM must not restart the burst.
    exp_sum = 8'h12; d0 = dones;
    start = 1'b1;
    tick();
    model_clear();
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    beat(8'h07, 1'b1);
    start = 1'b0;
    check("hold_count_const", count, 3);
    end_burst("hold", d0);
    tick();
    check("hold_stay_idle", busy, 0);

    check("sb_empty", sb.size(), 0);
    check("total_dones", dones, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
